// File: rtl/serial_comp_msb.sv
// Sequential MSB-first unsigned magnitude comparator with one-hot LG/EQ/RG result.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_comp_msb #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             LG_OUT,
  output logic             EQ_OUT,
  output logic             RG_OUT
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [IDX_W-1:0] idx_r;
  logic             found_r;
  logic             gt_r;
  logic             busy_r;
  logic             done_r;
  logic             lg_r;
  logic             eq_r;
  logic             rg_r;
  logic             x_bit_s;
  logic             y_bit_s;
  logic             found_s;
  logic             gt_s;
  logic             last_s;

  // Bit-slice evaluation and next-state selection
  always_comb begin
    state_s = state_r;
    x_bit_s = x_r[idx_r];
    y_bit_s = y_r[idx_r];
    found_s = found_r | (x_bit_s ^ y_bit_s);
    // the first recorded difference is sticky
    gt_s    = found_r ? gt_r : x_bit_s;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    last_s  = (idx_r == '0) || found_s;
`else
    last_s  = (idx_r == '0);
`endif
    case (state_r)
      IDLE: begin
        if (START) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_s = FINISH;
        end else begin
          state_s = SCAN;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand, scan and registered-output updates
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      idx_r   <= '0;
      found_r <= 1'b0;
      gt_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      lg_r    <= 1'b0;
      eq_r    <= 1'b1;
      rg_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == FINISH);
      case (state_r)
        IDLE: begin
          if (START) begin
            x_r     <= X;
            y_r     <= Y;
            idx_r   <= IDX_MAX;
            found_r <= 1'b0;
            gt_r    <= 1'b0;
          end
        end
        SCAN: begin
          found_r <= found_s;
          gt_r    <= gt_s;
          if (last_s) begin
            lg_r <= found_s & gt_s;
            eq_r <= ~found_s;
            rg_r <= found_s & ~gt_s;
          end else begin
            idx_r <= idx_r - IDX_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign LG_OUT = lg_r;
  assign EQ_OUT = eq_r;
  assign RG_OUT = rg_r;

endmodule

// File: tb/tb_serial_comp_msb.sv
// Self-checking bench for serial_comp_msb: cycle model of busy/done/result plus
// directed vectors with hand-computed latencies and results.
module tb_serial_comp_msb;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         BUSY;
  logic         DONE;
  logic         LG_OUT;
  logic         EQ_OUT;
  logic         RG_OUT;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_comp_msb #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .X     (X),
    .Y     (Y),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .LG_OUT(LG_OUT),
    .EQ_OUT(EQ_OUT),
    .RG_OUT(RG_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Scan length k implied by the operands
  function automatic int scan_len(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = W;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    for (int i = 0; i < W; i++) begin
      if (a[i] != b[i]) k = W - i;
    end
`endif
    return k;
  endfunction

  function automatic logic [2:0] cmp_of(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    else if (a == b) return 3'b010;
    else return 3'b001;
  endfunction

  // Model: rem = busy cycles still to come, DONE in the last one
  int         rem = 0;
  logic [2:0] res = 3'b010;
  logic [2:0] pend = 3'b010;

  always @(posedge CLK) begin
    if (RST) begin
      rem <= 0;
      res <= 3'b010;
    end else if (rem == 0) begin
      if (START) begin
        rem  <= scan_len(X, Y) + 1;
        pend <= cmp_of(X, Y);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) res <= pend;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if ({BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT} !== {rem != 0, rem == 1, res}) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got busy/done/lg/eq/rg=%b expected %b", $time,
                 {BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT}, {rem != 0, rem == 1, res});
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [2:0] exp_res, input string nm);
    int lat;
    @(posedge CLK); #2;
    X = a; Y = b; START = 1'b1;
    @(posedge CLK); #2;
    START = 1'b0; X = ~a; Y = ~b;
    lat = 0;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = n;
        break;
      end
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_result"}, int'({LG_OUT, EQ_OUT, RG_OUT}), int'(exp_res));
  endtask

  initial begin
    int n1;
    int n2;
    RST = 1'b1; START = 1'b0; X = '0; Y = '0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    check("reset_state", int'({BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT}), int'(5'b00010));

`ifdef SERIAL_COMP_EARLY_EXIT_EN
    run_op(4'b1000, 4'b0111, 2, 3'b100, "msb_lg");
    run_op(4'hA,    4'hA,    5, 3'b010, "eq_a");
    run_op(4'b0100, 4'b0110, 4, 3'b001, "bit1_rg");
    run_op(4'b0010, 4'b0011, 5, 3'b001, "lsb_rg");
    run_op(4'b0000, 4'b1111, 2, 3'b001, "msb_rg");
`else
    run_op(4'b1000, 4'b0111, 5, 3'b100, "msb_lg");
    run_op(4'hA,    4'hA,    5, 3'b010, "eq_a");
    run_op(4'b0100, 4'b0110, 5, 3'b001, "bit1_rg");
    run_op(4'b0010, 4'b0011, 5, 3'b001, "lsb_rg");
    run_op(4'b0000, 4'b1111, 5, 3'b001, "msb_rg");
`endif

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'(i);
      b = W'((i * 7 + 3) % 16);
      run_op(a, b, scan_len(a, b) + 1, cmp_of(a, b), "sweep");
    end

    // START held high; operands change right after the first capture
    @(posedge CLK); #2;
    X = 4'b1000; Y = 4'b0111; START = 1'b1;
    @(posedge CLK); #2;
    X = 4'b0000; Y = 4'b1111;
    n1 = 0; n2 = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge CLK);
      if (DONE) begin
        if (n1 == 0) begin
          n1 = t;
          check("held_first_result", int'({LG_OUT, EQ_OUT, RG_OUT}), int'(3'b100));
        end else begin
          n2 = t;
          check("held_second_result", int'({LG_OUT, EQ_OUT, RG_OUT}), int'(3'b001));
          START = 1'b0;
          break;
        end
      end
    end
    START = 1'b0;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    check("held_done_gap", n2 - n1, 3);
`else
    check("held_done_gap", n2 - n1, 6);
`endif

    // Reset in the middle of a scan
    @(posedge CLK); #2;
    X = 4'b0000; Y = 4'b1111; START = 1'b1;
    @(posedge CLK); #2;
    START = 1'b0;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
    @(posedge CLK); #2;
`endif
    RST = 1'b1;
    @(negedge CLK);
    check("abort_scan_busy", int'(BUSY), 1);
    check("abort_scan_done", int'(DONE), 0);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_after_state", int'({BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT}), int'(5'b00010));
    for (int t = 0; t < 6; t++) begin
      @(negedge CLK);
      check("abort_no_done", int'(DONE), 0);
    end
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    run_op(4'b0000, 4'b1111, 2, 3'b001, "post_abort");
`else
    run_op(4'b0000, 4'b1111, 5, 3'b001, "post_abort");
`endif

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_comp_msb.md
# serial_comp_msb

Sequential MSB-first magnitude comparator for WIDTH-bit unsigned operands. It scans one bit per clock and returns the same one-hot LG/EQ/RG result encoding as the combinational ripple comparator. That comparator ripples LSB-first; this block resolves from the other end. It serves control paths where a parallel compare is too wide, or where compare time must be data-independent (constant-time keystream/state checks).

## Interface
- WIDTH, 4, operand width in bits; legal range 1..32.

- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request; sampled only while BUSY=0.
- X  in  WIDTH  left operand; captured on accepted START.
- Y  in  WIDTH  right operand; captured on accepted START.
- BUSY  out  1  high whenever state is not IDLE.
- DONE  out  1  one-cycle pulse; result valid.
- LG_OUT  out  1  X > Y.
- EQ_OUT  out  1  X == Y.
- RG_OUT  out  1  X < Y.

## Operation
- States: IDLE, SCAN, FINISH.
- IDLE
  - START=1 latches X and Y into internal registers.
  - Bit index loads to WIDTH-1; go to SCAN.
- SCAN: each cycle compares latched bit[idx] of X and Y.
  - Bits differ with no difference yet recorded: record LG (X bit=1) or RG (Y bit=1).
  - Later differences never overwrite the first one recorded.
  - idx decrements each cycle.
  - Leave SCAN after the idx=0 cycle, or earlier (see Configuration).
  - No difference recorded by then: result is EQ.
- FINISH
  - DONE=1 for this single cycle.
  - LG_OUT/EQ_OUT/RG_OUT take the final result this cycle.
  - Next state is IDLE.
- Result outputs are registered.
  - They hold their value from FINISH until the next FINISH or reset.
  - They do not change during SCAN.
- Outputs are always one-hot: exactly one of LG_OUT/EQ_OUT/RG_OUT is high, including at reset.
- START while BUSY=1 (including the FINISH cycle) is ignored; no queueing.
- X/Y changes after capture have no effect on the operation in progress.
- Reset values: state IDLE, BUSY=0, DONE=0, LG_OUT=0, EQ_OUT=1, RG_OUT=0, index and operand registers 0.
- RST during SCAN or FINISH aborts the operation:
  - no DONE is produced;
  - outputs return to reset values on the next edge.

## Timing
- START accepted at edge 0; SCAN occupies cycles 1..k; FINISH (DONE=1) is cycle k+1.
- BUSY=1 during cycles 1..k+1; BUSY=0 from cycle k+2.
- A new START can be accepted in cycle k+2, i.e. back-to-back with one idle edge.
- k=WIDTH for EQ results, and for all results when early exit is disabled.
- With early exit, k = WIDTH-i, where i is the highest differing bit position.
- Minimum latency START→DONE: 2 cycles (MSB differs, early exit).
- Maximum latency: WIDTH+1 cycles.
- WIDTH=1: SCAN lasts exactly one cycle in all cases.

## Configuration
- Macro SERIAL_COMP_EARLY_EXIT_EN.
- Defined: SCAN ends in the same cycle the first differing bit is found, so latency is data-dependent.
- Undefined: SCAN always runs all WIDTH cycles, so latency is a constant WIDTH+1. Required for timing-side-channel-sensitive use. Results are identical either way.

## Test plan
- WIDTH=4, X=4'b1000, Y=4'b0111, START at cycle 0:
  - macro defined → DONE at cycle 2, LG_OUT=1;
  - macro undefined → DONE at cycle 5, LG_OUT=1.
- X=Y=4'hA → DONE at cycle 5 (both configs), EQ_OUT=1, LG_OUT=RG_OUT=0.
- X=4'b0100, Y=4'b0110 → RG_OUT=1; DONE at cycle 4 (early exit) or cycle 5.
- X=4'b0010, Y=4'b0011 → RG_OUT=1, DONE at cycle 5 in both configs.
- START held high continuously with changing X/Y:
  - START in the FINISH cycle is ignored;
  - next capture happens at the edge after DONE drops;
  - the result reflects the operands captured at that edge.
- RST asserted during SCAN cycle 2 of X=0, Y=15:
  - no DONE pulse;
  - next cycle BUSY=0, EQ_OUT=1, LG_OUT=RG_OUT=0;
  - a subsequent START completes normally with RG_OUT=1.
